// File: rtl/counter_arbiter_pkg.sv
// Shared encodings, sizes and helpers for the counter_arbiter block.
package counter_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int HOLD_W  = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_GRANT = 2'b01,
    ST_GAP   = 2'b10
  } state_e;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [1:0] id);
    onehot = {{(NUM_REQ-1){1'b0}}, 1'b1} << id;
  endfunction

endpackage

// File: rtl/counter_arbiter_dff.sv
// Plain register with active-high asynchronous clear to zero.
module dff #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         arst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // State flop, cleared immediately by arst.
  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      q <= '0;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/counter_arbiter_rr_pick4.sv
// Combinational round-robin search over four requests starting at ptr.
module rr_pick4 (
  input  logic [3:0] req,
  input  logic [1:0] ptr,
  output logic [1:0] win_id,
  output logic       win_valid
);

  logic [1:0] idx;

  // Scan from farthest to nearest so the closest set bit to ptr wins last.
  always_comb begin
    win_id    = 2'd0;
    win_valid = 1'b0;
    idx       = 2'd0;
    for (int k = 3; k >= 0; k--) begin
      idx       = ptr + 2'(k);
      win_id    = req[idx] ? idx : win_id;
      win_valid = req[idx] | win_valid;
    end
  end

endmodule

// File: rtl/counter_arbiter.sv
// Round-robin owner selection for the shared counter with hold limit,
// forced revoke and illegal-state trap, all outputs registered.
module counter_arbiter
  import counter_arbiter_pkg::*;
#(
  parameter int HOLD_MAX = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [1:0]         gnt_id,
  output logic               busy,
  output logic               err
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(HOLD_MAX - 1);

  logic               arst;
  logic [1:0]         state_q, state_d;
  logic [1:0]         ptr_q, ptr_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [1:0]         gnt_id_q, gnt_id_d;
  logic               busy_q, busy_d;
  logic               err_q, err_d;
  logic [1:0]         win_id;
  logic               win_valid;

  assign arst = ~rst;

  rr_pick4 u_pick (
    .req       (req),
    .ptr       (ptr_q),
    .win_id    (win_id),
    .win_valid (win_valid)
  );

  dff #(.W(2))       u_state  (.clk(clk), .arst(arst), .d(state_d),  .q(state_q));
  dff #(.W(2))       u_ptr    (.clk(clk), .arst(arst), .d(ptr_d),    .q(ptr_q));
  dff #(.W(HOLD_W))  u_hold   (.clk(clk), .arst(arst), .d(hold_d),   .q(hold_q));
  dff #(.W(NUM_REQ)) u_gnt    (.clk(clk), .arst(arst), .d(gnt_d),    .q(gnt_q));
  dff #(.W(2))       u_gnt_id (.clk(clk), .arst(arst), .d(gnt_id_d), .q(gnt_id_q));
  dff #(.W(1))       u_busy   (.clk(clk), .arst(arst), .d(busy_d),   .q(busy_q));
  dff #(.W(1))       u_err    (.clk(clk), .arst(arst), .d(err_d),    .q(err_q));

  // Next-state and next-output logic; any path without a grant leaves
  // gnt/gnt_id/busy at zero, and ptr moves only on a GRANT exit.
  always_comb begin
    state_d  = state_q;
    ptr_d    = ptr_q;
    hold_d   = hold_q;
    gnt_d    = {NUM_REQ{1'b0}};
    gnt_id_d = 2'd0;
    busy_d   = 1'b0;
    err_d    = 1'b0;
    if (clr) begin
      state_d = ST_IDLE;
      ptr_d   = 2'd0;
      hold_d  = {HOLD_W{1'b0}};
    end else begin
      case (state_q)
        ST_IDLE, ST_GAP: begin
          hold_d = {HOLD_W{1'b0}};
          if (win_valid) begin
            state_d  = ST_GRANT;
            gnt_d    = onehot(win_id);
            gnt_id_d = win_id;
            busy_d   = 1'b1;
          end else begin
            state_d  = ST_IDLE;
          end
        end
        ST_GRANT: begin
          if (req[gnt_id_q] && (hold_q < HOLD_LAST)) begin
            hold_d   = hold_q + {{(HOLD_W-1){1'b0}}, 1'b1};
            gnt_d    = gnt_q;
            gnt_id_d = gnt_id_q;
            busy_d   = 1'b1;
          end else begin
            // Release or timeout; a still-asserted request means revoke.
            state_d = ST_GAP;
            ptr_d   = gnt_id_q + 2'd1;
            hold_d  = {HOLD_W{1'b0}};
            err_d   = req[gnt_id_q];
          end
        end
        default: begin
          state_d = ST_IDLE;
          hold_d  = {HOLD_W{1'b0}};
          err_d   = 1'b1;
        end
      endcase
    end
  end

  assign gnt    = gnt_q;
  assign gnt_id = gnt_id_q;
  assign busy   = busy_q;
  assign err    = err_q;

endmodule
